// File: rtl/cpu_pkg.sv
// Shared CPU datapath types.
// Word width and the word type used by every 10-bit register.
`timescale 1ns/1ps
package cpu_pkg;

    localparam int WORD_W = 10;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/ten_bit_reg_if.sv
// Write port and read-back bundle of a 10-bit datapath register.
// The master drives d/w, the register (slave) returns q.
`timescale 1ns/1ps
interface ten_bit_reg_if;
    import cpu_pkg::*;

    word_t d;
    logic  w;
    word_t q;

    modport master (
        output d,
        output w,
        input  q
    );

    modport slave (
        input  d,
        input  w,
        output q
    );

endinterface

// File: rtl/dff_en_bit.sv
// One bit of a datapath register with synchronous reset and load enable.
// Holds INIT_BIT from power-up until the first load or reset.
`timescale 1ns/1ps
module dff_en_bit #(
    parameter logic INIT_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic w,
    output logic q
);

    logic q_d;
    // Power-up value matches the reset value so q is never X.
    logic q_q = INIT_BIT;

    always_comb begin
        q_d = q_q;
        if (w) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= INIT_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ten_bit_reg.sv
// 10-bit general-purpose register: sync reset to INIT, load on w.
// Built from per-bit enable flops so INIT is applied bit by bit.
`timescale 1ns/1ps
module ten_bit_reg
    import cpu_pkg::*;
#(
    parameter word_t INIT = 10'd0
) (
    input  logic             clk,
    input  logic             rst,
    ten_bit_reg_if.slave     bus
);

    word_t q_w;

    for (genvar i = 0; i < WORD_W; i++) begin : g_bit
        dff_en_bit #(
            .INIT_BIT (INIT[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .d   (bus.d[i]),
            .w   (bus.w),
            .q   (q_w[i])
        );
    end

    assign bus.q = q_w;

endmodule

// File: tb/tb_ten_bit_reg.sv
// Directed self-checking bench for ten_bit_reg (INIT = 992).
`timescale 1ns/1ps
module tb_ten_bit_reg;
    import cpu_pkg::*;

    localparam word_t INIT_V = 10'b1111100000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    real  t_pos = -1.0;

    ten_bit_reg_if bus ();

    ten_bit_reg #(
        .INIT (INIT_V)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #1 clk = ~clk;

    always @(posedge clk) t_pos = $realtime;

    // q may only move in the same timestep as a rising edge.
    always @(bus.q) begin
        if ($realtime > 0.0) begin
            checks++;
            assert ($realtime == t_pos) else begin
                failures++;
                $error("FAIL q_edge_only: q changed at %0t, last posedge %0t",
                       $realtime, t_pos);
            end
        end
    end

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        bus.d = '0;
        bus.w = 1'b0;
        #0.5;
        chk("powerup", bus.q, 10'd992);

        bus.d = 10'd45;
        bus.w = 1'b1;
        @(negedge clk);
        chk("wr_45", bus.q, 10'd45);

        bus.d = 10'd54;
        @(negedge clk);
        chk("wr_54", bus.q, 10'd54);

        bus.d = 10'd100;
        bus.w = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_54", bus.q, 10'd54);
        end

        bus.d = 10'd101;
        bus.w = 1'b1;
        @(negedge clk);
        chk("wr_101", bus.q, 10'd101);

        bus.d = 10'd105;
        @(negedge clk);
        chk("wr_105", bus.q, 10'd105);

        bus.d = 10'd0;
        bus.w = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_105", bus.q, 10'd105);
        end

        bus.w = 1'b1;
        @(negedge clk);
        chk("wr_0", bus.q, 10'd0);

        rst   = 1'b1;
        bus.d = 10'h3FF;
        @(negedge clk);
        chk("rst_prio", bus.q, 10'd992);

        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", bus.q, 10'd992);
        end

        rst   = 1'b0;
        bus.d = 10'd7;
        @(negedge clk);
        chk("rst_release", bus.q, 10'd7);

        bus.d = 10'd1000;
        @(negedge clk);
        chk("wr_1000", bus.q, 10'd1000);

        // Mid-cycle toggles must not reach q before the edge.
        rst   = 1'b1;
        #0.2;
        rst   = 1'b0;
        bus.d = 10'd300;
        #0.3;
        chk("no_comb_d", bus.q, 10'd1000);
        bus.d = 10'd1;
        bus.w = 1'b0;
        @(posedge clk);
        #0.5;
        chk("sample_w0", bus.q, 10'd1000);

        @(negedge clk);
        bus.w = 1'b1;
        bus.d = 10'd300;
        #0.3;
        bus.d = 10'd513;
        @(posedge clk);
        #0.5;
        chk("sample_d", bus.q, 10'd513);

        @(negedge clk);
        rst   = 1'b1;
        bus.d = 10'd2;
        #0.3;
        chk("no_comb_rst", bus.q, 10'd513);
        rst = 1'b0;
        @(posedge clk);
        #0.5;
        chk("rst_pulse_gone", bus.q, 10'd2);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #0.5;
        chk("rst_again", bus.q, 10'd992);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
